// File: rtl/lif_pkg.sv
// Shared definitions for the LIF spike observers: default widths, FSM state type
// and the saturation ceiling of the default count width.
package lif_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 8;

    localparam logic [CNT_W_DEF-1:0] SAT_MAX_DEF = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and load-one controls. ovf_o is sticky: it is set
// by an increment that hits the ceiling and stays set until the next clear or load.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load1_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load1_i) begin
            cnt_d = ONE;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/spike_rate_meter.sv
// Spike-rate (spikes per programmable window) and inter-spike-interval observer.
// Define SPIKE_RATE_EDGE_EN to qualify spikes on rising edges of spike_in instead of level.
module spike_rate_meter
    import lif_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             rate_sat,
    output logic [CNT_W-1:0] isi_out,
    output logic             isi_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    state_e           state_q, state_d;
    logic [WIN_W-1:0] n_q, n_d;
    logic [WIN_W-1:0] cyc_q, cyc_d;
    logic             have_prev_q, have_prev_d;
    logic [CNT_W-1:0] rate_out_q, rate_out_d;
    logic             rate_valid_q, rate_valid_d;
    logic             rate_sat_q, rate_sat_d;
    logic [CNT_W-1:0] isi_out_q, isi_out_d;
    logic             isi_valid_q, isi_valid_d;

    logic             spike;
    logic             acc_clr, acc_inc, acc_ovf;
    logic [CNT_W-1:0] acc;
    logic             isi_clr, isi_load1, isi_inc;
    logic [CNT_W-1:0] isi_cnt;
    logic             isi_ovf_unused;
    logic             last_cyc;
    logic [CNT_W-1:0] rate_next;
    logic             rate_ovf_next;

`ifdef SPIKE_RATE_EDGE_EN
    logic spike_prev_q, spike_prev_d;

    assign spike = spike_in & ~spike_prev_q;

    // Previous sample only tracks while staying in RUN, so a level already high
    // at (re)entry still counts as one fresh edge.
    always_comb begin
        spike_prev_d = 1'b0;
        if (state_q == RUN && state_d == RUN) begin
            spike_prev_d = spike_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_prev_q <= 1'b0;
        end else begin
            spike_prev_q <= spike_prev_d;
        end
    end
`else
    assign spike = spike_in;
`endif

    sat_counter #(.W(CNT_W)) u_acc (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (acc_clr),
        .load1_i (1'b0),
        .inc_i   (acc_inc),
        .cnt_o   (acc),
        .ovf_o   (acc_ovf)
    );

    sat_counter #(.W(CNT_W)) u_isi (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (isi_clr),
        .load1_i (isi_load1),
        .inc_i   (isi_inc),
        .cnt_o   (isi_cnt),
        .ovf_o   (isi_ovf_unused)
    );

    assign last_cyc      = (cyc_q == (n_q - WIN_ONE));
    assign rate_next     = (acc == CNT_MAX) ? CNT_MAX : acc + {{(CNT_W-1){1'b0}}, spike};
    assign rate_ovf_next = acc_ovf | ((acc == CNT_MAX) & spike);

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        cyc_d        = cyc_q;
        have_prev_d  = have_prev_q;
        rate_out_d   = rate_out_q;
        rate_valid_d = 1'b0;
        rate_sat_d   = rate_sat_q;
        isi_out_d    = isi_out_q;
        isi_valid_d  = 1'b0;
        acc_clr      = 1'b0;
        acc_inc      = 1'b0;
        isi_clr      = 1'b0;
        isi_load1    = 1'b0;
        isi_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                acc_clr     = 1'b1;
                isi_clr     = 1'b1;
                have_prev_d = 1'b0;
                cyc_d       = '0;
                if (enable && window != '0) begin
                    state_d = RUN;
                    n_d     = window;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d     = IDLE;
                    acc_clr     = 1'b1;
                    isi_clr     = 1'b1;
                    have_prev_d = 1'b0;
                    cyc_d       = '0;
                end else begin
                    if (spike) begin
                        if (have_prev_q) begin
                            isi_out_d   = isi_cnt;
                            isi_valid_d = 1'b1;
                        end
                        isi_load1   = 1'b1;
                        have_prev_d = 1'b1;
                    end else begin
                        isi_inc = 1'b1;
                    end

                    // A spike on the closing cycle is folded into rate_next.
                    if (last_cyc) begin
                        rate_out_d   = rate_next;
                        rate_sat_d   = rate_ovf_next;
                        rate_valid_d = 1'b1;
                        acc_clr      = 1'b1;
                        cyc_d        = '0;
                        n_d          = window;
                        if (window == '0) begin
                            state_d     = IDLE;
                            have_prev_d = 1'b0;
                        end
                    end else begin
                        acc_inc = spike;
                        cyc_d   = cyc_q + WIN_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            cyc_q        <= '0;
            have_prev_q  <= 1'b0;
            rate_out_q   <= '0;
            rate_valid_q <= 1'b0;
            rate_sat_q   <= 1'b0;
            isi_out_q    <= '0;
            isi_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            cyc_q        <= cyc_d;
            have_prev_q  <= have_prev_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
            rate_sat_q   <= rate_sat_d;
            isi_out_q    <= isi_out_d;
            isi_valid_q  <= isi_valid_d;
        end
    end

    assign rate_out   = rate_out_q;
    assign rate_valid = rate_valid_q;
    assign rate_sat   = rate_sat_q;
    assign isi_out    = isi_out_q;
    assign isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_meter.sv
// Self-checking bench for spike_rate_meter (level mode, CNT_W=4 so saturation is reachable).
module tb_spike_rate_meter;

    localparam int CW   = 4;
    localparam int WW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          spike_in;
    logic [WW-1:0] window;
    logic [CW-1:0] rate_out;
    logic          rate_valid;
    logic          rate_sat;
    logic [CW-1:0] isi_out;
    logic          isi_valid;

    spike_rate_meter #(.CNT_W(CW), .WIN_W(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike_in   (spike_in),
        .window     (window),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_sat   (rate_sat),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: spikes are timestamped; the rate is the plain count in the
    // window, the ISI is the difference of timestamps, both clipped at MAXV.
    bit m_run;
    int m_n, m_pos, m_cnt, m_last, m_t;
    int m_rate, m_isi;
    bit m_sat, m_rv, m_iv;

    typedef struct {
        bit en;
        int win;
        bit spk;
        bit rv;
        int rate;
        bit iv;
        int isi;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_n = 0; m_pos = 0; m_cnt = 0; m_last = -1; m_t = 0;
        m_rate = 0; m_isi = 0; m_sat = 0; m_rv = 0; m_iv = 0;
    endtask

    task automatic model_step(input bit en, input int win, input bit spk);
        m_rv = 0;
        m_iv = 0;
        if (!m_run) begin
            if (en && win != 0) begin
                m_run = 1; m_n = win; m_pos = 0; m_cnt = 0; m_last = -1;
            end
        end else if (!en) begin
            m_run = 0;
            m_last = -1;
        end else begin
            if (spk) begin
                m_cnt++;
                if (m_last >= 0) begin
                    m_isi = (m_t - m_last > MAXV) ? MAXV : m_t - m_last;
                    m_iv  = 1;
                end
                m_last = m_t;
            end
            if (m_pos == m_n - 1) begin
                m_rate = (m_cnt > MAXV) ? MAXV : m_cnt;
                m_sat  = (m_cnt > MAXV);
                m_rv   = 1;
                m_cnt  = 0;
                m_pos  = 0;
                m_n    = win;
                if (win == 0) begin
                    m_run  = 0;
                    m_last = -1;
                end
            end else begin
                m_pos++;
            end
        end
        m_t++;
    endtask

    task automatic check_model();
        chk("rate_out", int'(rate_out), m_rate);
        chk("rate_valid", int'(rate_valid), int'(m_rv));
        chk("rate_sat", int'(rate_sat), int'(m_sat));
        chk("isi_out", int'(isi_out), m_isi);
        chk("isi_valid", int'(isi_valid), int'(m_iv));
    endtask

    task automatic step(input bit en, input int win, input bit spk);
        @(negedge clk);
        enable   = en;
        window   = WW'(win);
        spike_in = spk;
        @(posedge clk);
        model_step(en, win, spk);
        #1;
        check_model();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rate_out"}, int'(rate_out), 0);
        chk({tag, "_rate_valid"}, int'(rate_valid), 0);
        chk({tag, "_rate_sat"}, int'(rate_sat), 0);
        chk({tag, "_isi_out"}, int'(isi_out), 0);
        chk({tag, "_isi_valid"}, int'(isi_valid), 0);
    endtask

    initial begin
        int pulses, ipulses, dens, win;
        bit en;

        // window=4 walk: spikes on RUN cycles 0, 2 and 3 (last), then an empty window
        tbl[0] = '{1, 4, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 4, 1, 0, 0, 0, 0};
        tbl[2] = '{1, 4, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 4, 1, 0, 0, 1, 2};
        tbl[4] = '{1, 4, 1, 1, 3, 1, 1};
        tbl[5] = '{1, 4, 0, 0, 3, 0, 1};
        tbl[6] = '{1, 4, 0, 0, 3, 0, 1};
        tbl[7] = '{1, 4, 0, 0, 3, 0, 1};
        tbl[8] = '{1, 4, 0, 1, 0, 0, 1};
        tbl[9] = '{0, 4, 0, 0, 0, 0, 1};

        rst = 1'b1; enable = 1'b0; spike_in = 1'b0; window = '0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // silent input: a zero-count report every 10 cycles, no ISI
        pulses = 0; ipulses = 0;
        for (int i = 0; i < 35; i++) begin
            step(1, 10, 0);
            if (rate_valid) pulses++;
            if (isi_valid) ipulses++;
        end
        chk("silent_rate_pulses", pulses, 3);
        chk("silent_isi_pulses", ipulses, 0);
        step(0, 10, 0);
        step(0, 10, 0);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].win, tbl[i].spk);
            chk("tbl_rate_valid", int'(rate_valid), int'(tbl[i].rv));
            chk("tbl_rate_out", int'(rate_out), tbl[i].rate);
            chk("tbl_isi_valid", int'(isi_valid), int'(tbl[i].iv));
            chk("tbl_isi_out", int'(isi_out), tbl[i].isi);
        end

        // every third cycle from two cycles after entry
        step(1, 10, 0);
        for (int i = 0; i < 45; i++) begin
            step(1, 10, (i % 3) == 1);
        end
        step(0, 10, 0);

        // tied high into a 20-cycle window: count saturates at 15
        pulses = 0;
        step(1, 20, 1);
        for (int i = 0; i < 45; i++) begin
            step(1, 20, 1);
            if (rate_valid) begin
                pulses++;
                chk("tied_rate_out", int'(rate_out), MAXV);
                chk("tied_rate_sat", int'(rate_sat), 1);
            end
        end
        chk("tied_rate_pulses", pulses, 2);
        step(0, 20, 0);

        // abort at cycle 5 of a 10-cycle window, then re-arm
        pulses = 0;
        step(1, 10, 0);
        step(1, 10, 1);
        step(1, 10, 0);
        step(1, 10, 1);
        step(1, 10, 0);
        step(0, 10, 1);
        for (int i = 0; i < 12; i++) begin
            step(0, 10, 0);
            if (rate_valid) pulses++;
        end
        chk("abort_rate_pulses", pulses, 0);
        ipulses = 0;
        step(1, 10, 0);
        step(1, 10, 1);
        if (isi_valid) ipulses++;
        step(1, 10, 0);
        step(1, 10, 0);
        step(1, 10, 1);
        chk("rearm_isi_valid", int'(isi_valid), 1);
        chk("rearm_isi_out", int'(isi_out), 3);
        chk("rearm_first_spike_quiet", ipulses, 0);

        // async reset mid-window with four spikes accumulated
        step(1, 10, 0);
        step(1, 10, 1);
        step(1, 10, 1);
        step(1, 10, 0);
        step(1, 10, 1);
        step(1, 10, 1);
        #2;
        rst = 1'b1;
        enable = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        pulses = 0; ipulses = 0;
        for (int i = 0; i < 25; i++) begin
            step(1, 10, 0);
            if (rate_valid) pulses++;
            if (isi_valid) ipulses++;
        end
        chk("post_rst_rate_pulses", pulses, 2);
        chk("post_rst_isi_pulses", ipulses, 0);

        // randomized traffic against the model
        win = 7; dens = 30;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 5) win = $urandom_range(0, 30);
            if ($urandom_range(0, 99) < 3) dens = $urandom_range(0, 100);
            en = ($urandom_range(0, 99) < 96);
            step(en, win, $urandom_range(0, 99) < dens);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
